// File: rtl/tl_pkg.sv
// Shared TileLink definitions: A-channel opcodes, fixed field widths and
// helpers that derive the widths of the merged source field.
package tl_pkg;

   typedef enum logic [2:0] {
      PUT_FULL_DATA    = 3'd0,
      PUT_PARTIAL_DATA = 3'd1,
      ARITHMETIC_DATA  = 3'd2,
      LOGICAL_DATA     = 3'd3,
      GET              = 3'd4,
      INTENT           = 3'd5,
      ACQUIRE_BLOCK    = 3'd6,
      ACQUIRE_PERM     = 3'd7
   } tl_a_opcode_e;

   localparam int TL_OPW    = 3;
   localparam int TL_PARAMW = 3;
   localparam int TL_SIZEW  = 8;
   localparam int TL_MASKW  = 16;
   localparam int TL_DATAW  = 128;

   // At least one bit, so a single-source or single-port build still has a field.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Inner source id width for NoRPM sources per port.
   function automatic int src_w(input int norpm);
      return clog2_min1(norpm);
   endfunction

   // Port index width: TUL TL-UL ports plus the two cached ports.
   function automatic int pid_w(input int tul);
      return clog2_min1(tul + 2);
   endfunction

   // Packed width of one stored A beat.
   function automatic int a_beat_w(input int madrbits, input int srcw_total);
      return TL_OPW + TL_PARAMW + TL_SIZEW + srcw_total + madrbits + TL_MASKW + TL_DATAW + 1;
   endfunction

endpackage

// File: rtl/tl_sync_fifo.sv
// Synchronous FWFT FIFO: storage, pointers, entry count and a sticky overflow
// flag. A push is taken at full only when a pop frees a slot in the same cycle.
module tl_sync_fifo #(
   parameter  int DW    = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_req,
   input  logic [DW-1:0] din,
   input  logic          pop_req,
   output logic [DW-1:0] dout,
   output logic          valid,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_next,
   output logic          overflow
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop, is_full;

   assign is_full    = (count == CW'(DEPTH));
   assign pop        = pop_req && (count != '0);
   assign push       = push_req && (!is_full || pop);
   assign count_next = count + CW'(push) - CW'(pop);
   assign valid      = (count != '0);
   assign dout       = mem[rd_ptr];

   // Control state: pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         if (push_req && !push) overflow <= 1'b1;
      end
   end

   // Payload storage needs no reset; entries are dead until counted in.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/tl_a_request_buffer.sv
// Queues the serialised TL A-channel stream ahead of the L2 request pipeline.
// The upstream has no ready, so backpressure is a registered full flag raised
// while SLACK entries are still free to absorb the beat already in flight.
module tl_a_request_buffer
   import tl_pkg::*;
#(
   parameter  int MADRBITS = 32,
   parameter  int NoRPM    = 2,
   parameter  int TUL      = 2,
   parameter  int DEPTH    = 8,
   parameter  int SLACK    = 2,
   localparam int SRCW     = src_w(NoRPM),
   localparam int PIDW     = pid_w(TUL),
   localparam int CNTW     = $clog2(DEPTH) + 1
) (
   input  logic                 l2_cache_clk_i,
   input  logic                 l2_cache_rst_ni,
   input  logic [2:0]           l2_a_opcode_i,
   input  logic [2:0]           l2_a_param_i,
   input  logic [7:0]           l2_a_size_i,
   input  logic [PIDW+SRCW-1:0] l2_a_source_i,
   input  logic [MADRBITS-1:0]  l2_a_address_i,
   input  logic [15:0]          l2_a_mask_i,
   input  logic [127:0]         l2_a_data_i,
   input  logic                 l2_a_corrupt_i,
   input  logic                 l2_a_valid_i,
   output logic                 l2_buffers_full_o,
   output logic [2:0]           req_opcode_o,
   output logic [2:0]           req_param_o,
   output logic [7:0]           req_size_o,
   output logic [MADRBITS-1:0]  req_address_o,
   output logic [15:0]          req_mask_o,
   output logic [127:0]         req_data_o,
   output logic                 req_corrupt_o,
   output logic [PIDW-1:0]      req_port_o,
   output logic [SRCW-1:0]      req_source_o,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [CNTW-1:0]      occupancy_o,
   output logic                 overflow_o
);

   localparam int BW = a_beat_w(MADRBITS, PIDW + SRCW);

   typedef struct packed {
      tl_a_opcode_e          opcode;
      logic [2:0]            param;
      logic [7:0]            size;
      logic [PIDW+SRCW-1:0]  source;
      logic [MADRBITS-1:0]   address;
      logic [15:0]           mask;
      logic [127:0]          data;
      logic                  corrupt;
   } tl_a_beat_t;

   tl_a_beat_t      in_beat, head_beat;
   logic [BW-1:0]   head_raw;
   logic [CNTW-1:0] count_next;

   // Opcode is carried opaque; the cast only gives it its TL name.
   always_comb begin
      in_beat         = '0;
      in_beat.opcode  = tl_a_opcode_e'(l2_a_opcode_i);
      in_beat.param   = l2_a_param_i;
      in_beat.size    = l2_a_size_i;
      in_beat.source  = l2_a_source_i;
      in_beat.address = l2_a_address_i;
      in_beat.mask    = l2_a_mask_i;
      in_beat.data    = l2_a_data_i;
      in_beat.corrupt = l2_a_corrupt_i;
   end

   tl_sync_fifo #(
      .DW    (BW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (l2_cache_clk_i),
      .rst_n      (l2_cache_rst_ni),
      .push_req   (l2_a_valid_i),
      .din        (in_beat),
      .pop_req    (req_ready_i),
      .dout       (head_raw),
      .valid      (req_valid_o),
      .count      (occupancy_o),
      .count_next (count_next),
      .overflow   (overflow_o)
   );

   assign head_beat     = tl_a_beat_t'(head_raw);
   assign req_opcode_o  = head_beat.opcode;
   assign req_param_o   = head_beat.param;
   assign req_size_o    = head_beat.size;
   assign req_address_o = head_beat.address;
   assign req_mask_o    = head_beat.mask;
   assign req_data_o    = head_beat.data;
   assign req_corrupt_o = head_beat.corrupt;
   assign req_port_o    = head_beat.source[PIDW+SRCW-1:SRCW];
   assign req_source_o  = head_beat.source[SRCW-1:0];

   // Full looks at next-cycle occupancy so the serialiser sees it one cycle early.
   always_ff @(posedge l2_cache_clk_i or negedge l2_cache_rst_ni) begin
      if (!l2_cache_rst_ni) l2_buffers_full_o <= 1'b0;
      else                  l2_buffers_full_o <= (count_next >= CNTW'(DEPTH - SLACK));
   end

endmodule

// File: tb/tb_tl_a_request_buffer.sv
// Directed and scoreboarded bench for tl_a_request_buffer (default parameters).
module tb_tl_a_request_buffer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   a_opcode, a_param;
   logic [7:0]   a_size;
   logic [2:0]   a_source;
   logic [31:0]  a_address;
   logic [15:0]  a_mask;
   logic [127:0] a_data;
   logic         a_corrupt, a_valid;
   logic         full;
   logic [2:0]   r_opcode, r_param;
   logic [7:0]   r_size;
   logic [31:0]  r_address;
   logic [15:0]  r_mask;
   logic [127:0] r_data;
   logic         r_corrupt;
   logic [1:0]   r_port;
   logic [0:0]   r_source;
   logic         r_valid, r_ready;
   logic [3:0]   occ;
   logic         ovf;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [2:0]   opcode;
      logic [2:0]   param;
      logic [7:0]   size;
      logic [2:0]   source;
      logic [31:0]  address;
      logic [15:0]  mask;
      logic [127:0] data;
      logic         corrupt;
   } beat_t;

   beat_t q[$];
   beat_t b;
   logic  prev_full;

   always #5 clk = ~clk;

   tl_a_request_buffer dut (
      .l2_cache_clk_i   (clk),
      .l2_cache_rst_ni  (rst_n),
      .l2_a_opcode_i    (a_opcode),
      .l2_a_param_i     (a_param),
      .l2_a_size_i      (a_size),
      .l2_a_source_i    (a_source),
      .l2_a_address_i   (a_address),
      .l2_a_mask_i      (a_mask),
      .l2_a_data_i      (a_data),
      .l2_a_corrupt_i   (a_corrupt),
      .l2_a_valid_i     (a_valid),
      .l2_buffers_full_o(full),
      .req_opcode_o     (r_opcode),
      .req_param_o      (r_param),
      .req_size_o       (r_size),
      .req_address_o    (r_address),
      .req_mask_o       (r_mask),
      .req_data_o       (r_data),
      .req_corrupt_o    (r_corrupt),
      .req_port_o       (r_port),
      .req_source_o     (r_source),
      .req_valid_o      (r_valid),
      .req_ready_i      (r_ready),
      .occupancy_o      (occ),
      .overflow_o       (ovf)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t head();
      beat_t h;
      h = {r_opcode, r_param, r_size, r_port, r_source, r_address, r_mask, r_data, r_corrupt};
      return h;
   endfunction

   function automatic beat_t mk(input int id);
      beat_t x;
      x.opcode  = 3'(id);
      x.param   = 3'(id + 1);
      x.size    = 8'(id);
      x.source  = 3'(id);
      x.address = 32'h1000_0000 + 32'(id) * 32'h40;
      x.mask    = 16'hFFFF;
      x.data    = {4{32'(id)}};
      x.corrupt = id[0];
      return x;
   endfunction

   task automatic drive(input beat_t x, input logic v);
      {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt} = x;
      a_valid = v;
   endtask

   // One cycle: inputs held across the next posedge, back at the following negedge.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; r_ready = 1'b0; drive('0, 1'b0);
      repeat (2) step();
      chk("rst_valid", 256'(r_valid), 256'(0));
      chk("rst_occ",   256'(occ),     256'(0));
      chk("rst_full",  256'(full),    256'(0));
      chk("rst_ovf",   256'(ovf),     256'(0));
      rst_n = 1'b1;
      step();

      // Latency: a Get into an empty queue is visible one cycle later.
      b = '0; b.opcode = 3'd4; b.source = 3'b101; b.address = 32'h8000_0040; b.mask = 16'h00FF;
      drive(b, 1'b1);
      chk("lat_not_bypass", 256'(r_valid), 256'(0));
      step(); drive('0, 1'b0);
      chk("lat_valid",  256'(r_valid),   256'(1));
      chk("lat_port",   256'(r_port),    256'(2));
      chk("lat_src",    256'(r_source),  256'(1));
      chk("lat_opcode", 256'(r_opcode),  256'(4));
      chk("lat_addr",   256'(r_address), 256'h8000_0040);
      r_ready = 1'b1; step(); r_ready = 1'b0;
      chk("lat_drained", 256'(occ), 256'(0));

      // Fill with ready low; full rises after the 6th push, a 7th trailing beat fits.
      for (int i = 1; i <= 7; i++) begin
         drive(mk(i), 1'b1); step();
         chk($sformatf("fill_full_%0d", i), 256'(full), 256'(i >= 6));
      end
      drive('0, 1'b0);
      chk("fill_occ7", 256'(occ), 256'(7));
      chk("fill_ovf",  256'(ovf), 256'(0));
      drive(mk(8), 1'b1); step();
      chk("fill_occ8", 256'(occ), 256'(8));

      // Push+pop at count 8: occupancy holds, beat 1 leaves, beat 9 enters.
      chk("pp_head_before", 256'(head()), 256'(mk(1)));
      drive(mk(9), 1'b1); r_ready = 1'b1; step(); r_ready = 1'b0;
      chk("pp_occ",  256'(occ),    256'(8));
      chk("pp_ovf",  256'(ovf),    256'(0));
      chk("pp_head", 256'(head()), 256'(mk(2)));

      // Violating push at count 8: dropped, overflow sticky, contents intact.
      drive(mk(10), 1'b1); step(); drive('0, 1'b0);
      chk("ov_flag", 256'(ovf),    256'(1));
      chk("ov_occ",  256'(occ),    256'(8));
      chk("ov_head", 256'(head()), 256'(mk(2)));
      step();
      chk("ov_sticky", 256'(ovf), 256'(1));

      // Drain in order: 2..9.
      r_ready = 1'b1;
      for (int i = 2; i <= 9; i++) begin
         chk($sformatf("drain_%0d", i), 256'(head()), 256'(mk(i)));
         step();
      end
      r_ready = 1'b0;
      chk("drain_empty", 256'(r_valid), 256'(0));
      chk("drain_full",  256'(full),    256'(0));

      // Asynchronous reset mid-stream with 5 entries queued.
      for (int i = 20; i < 25; i++) begin drive(mk(i), 1'b1); step(); end
      drive('0, 1'b0);
      chk("mid_occ5", 256'(occ), 256'(5));
      #2 rst_n = 1'b0; #1;
      chk("arst_valid", 256'(r_valid), 256'(0));
      chk("arst_occ",   256'(occ),     256'(0));
      chk("arst_full",  256'(full),    256'(0));
      chk("arst_ovf",   256'(ovf),     256'(0));
      step(); rst_n = 1'b1; step();
      drive(mk(30), 1'b1); step(); drive('0, 1'b0);
      chk("post_rst_valid", 256'(r_valid), 256'(1));
      chk("post_rst_head",  256'(head()),  256'(mk(30)));
      r_ready = 1'b1; step(); r_ready = 1'b0;

      // Random traffic: upstream honours full with a one-cycle lag.
      prev_full = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         logic v, rdy;
         chk("rnd_occ",   256'(occ),     256'(q.size()));
         chk("rnd_valid", 256'(r_valid), 256'(q.size() != 0));
         chk("rnd_full",  256'(full),    256'(q.size() >= 6));
         if (q.size() != 0) chk("rnd_head", 256'(head()), 256'(q[0]));
         v   = !prev_full && ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         prev_full = full;
         b = {3'($urandom), 3'($urandom), 8'($urandom), 3'($urandom), $urandom,
              16'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom)};
         drive(b, v); r_ready = rdy;
         if (rdy && q.size() != 0) void'(q.pop_front());
         if (v) q.push_back(b);
         step();
      end
      drive('0, 1'b0); r_ready = 1'b0;
      chk("rnd_no_ovf", 256'(ovf), 256'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
